// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational 32-bit ALU between
// NREQ requesters, with a single tagged response channel back to them.

module alu_share_arbiter_chk #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst_n,
  input logic [NREQ-1:0] req_ready,
  input logic            in_idle,
  input logic            in_resp,
  input logic            rsp_valid
);

  // Structural invariants of the handshake, checked every active cycle
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(req_ready))
        else $error("alu_share_arbiter: req_ready not one-hot %b", req_ready);
      assert (in_idle || (req_ready == {NREQ{1'b0}}))
        else $error("alu_share_arbiter: req_ready asserted outside IDLE");
      assert (rsp_valid == in_resp)
        else $error("alu_share_arbiter: rsp_valid inconsistent with FSM state");
    end
  end

endmodule

module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [31:0]       alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic [3:0]        rsp_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_r;
  logic [IDW-1:0]  last_grant_r;
  logic [IDW-1:0]  id_r;
  logic [31:0]     alu_a_r;
  logic [31:0]     alu_b_r;
  logic [2:0]      alu_ctrl_r;
  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [31:0]     rsp_result_r;
  logic [3:0]      rsp_flags_r;

  logic [IDW-1:0]  grant_idx_s;
  logic            grant_found_s;
  logic [NREQ-1:0] grant_oh_s;
  logic [NREQ-1:0] req_ready_s;
  logic [31:0]     sel_a_s;
  logic [31:0]     sel_b_s;
  logic [2:0]      sel_op_s;
  logic            accept_s;

  // Round-robin search: scan from the highest offset down so the lowest
  // offset after last_grant wins the final override.
  always_comb begin : grant_search
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand_idx;
    cand_sum      = {(IDW+1){1'b0}};
    cand_idx      = {IDW{1'b0}};
    grant_idx_s   = {IDW{1'b0}};
    grant_found_s = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_sum      = {1'b0, last_grant_r} + (IDW+1)'(k);
      cand_idx      = (cand_sum >= (IDW+1)'(NREQ)) ? IDW'(cand_sum - (IDW+1)'(NREQ))
                                                   : IDW'(cand_sum);
      grant_idx_s   = req_valid[cand_idx] ? cand_idx : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[cand_idx];
    end
  end

  // One-hot grant and AND-OR operand mux for the winning requester
  always_comb begin
    grant_oh_s = {NREQ{1'b0}};
    sel_a_s    = 32'd0;
    sel_b_s    = 32'd0;
    sel_op_s   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh_s[i] = grant_found_s & (grant_idx_s == IDW'(i));
      sel_a_s       = sel_a_s  | ({32{grant_oh_s[i]}} & req_a[32*i +: 32]);
      sel_b_s       = sel_b_s  | ({32{grant_oh_s[i]}} & req_b[32*i +: 32]);
      sel_op_s      = sel_op_s | ({3{grant_oh_s[i]}}  & req_op[3*i +: 3]);
    end
  end

  // Grants are only offered from IDLE and never while reset is applied
  always_comb begin
    if (rst_n && (state_r == IDLE)) begin
      req_ready_s = grant_oh_s;
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  assign accept_s  = |(req_valid & req_ready_s);
  assign req_ready = req_ready_s;

  // Transaction FSM: latch operands on accept, capture ALU output, hold response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NREQ - 1);
      id_r         <= {IDW{1'b0}};
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_ctrl_r   <= 3'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {IDW{1'b0}};
      rsp_result_r <= 32'd0;
      rsp_flags_r  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a_r      <= sel_a_s;
            alu_b_r      <= sel_b_s;
            alu_ctrl_r   <= sel_op_s;
            id_r         <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            state_r      <= EXEC;
          end else begin
            state_r      <= IDLE;
          end
        end
        EXEC: begin
          rsp_result_r <= alu_result;
          rsp_flags_r  <= alu_flags;
          rsp_id_r     <= id_r;
          rsp_valid_r  <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_ctrl   = alu_ctrl_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;

  alu_share_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (req_ready_s),
    .in_idle   (state_r == IDLE),
    .in_resp   (state_r == RESP),
    .rsp_valid (rsp_valid_r)
  );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a behavioural ALU closes the loop.

module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_ctrl;
  logic [31:0]       alu_result;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic [3:0]        rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  // Behavioural ALU: flags {Z,N,V,C}, C is carry-out (no-borrow on SUB)
  always_comb begin
    logic [32:0] wide;
    wide       = 33'd0;
    alu_result = 32'd0;
    alu_flags  = 4'd0;
    case (alu_ctrl)
      3'b000: begin
        wide       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[31:0];
        alu_flags[1] = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
        alu_flags[0] = wide[32];
      end
      3'b001: begin
        wide       = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = wide[31:0];
        alu_flags[1] = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
        alu_flags[0] = wide[32];
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'd0;
    endcase
    alu_flags[3] = (alu_result == 32'd0);
    alu_flags[2] = alu_result[31];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // Single ADD from requester 0; operands must freeze after accept
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd3;
    req_op[2:0] = 3'b000;
    req_valid   = 4'b0001;
    rsp_ready   = 1'b1;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    step();
    req_a[31:0] = 32'hDEAD_BEEF;
    req_valid   = 4'b0000;
    #1;
    chk("t1_ready_exec", 64'(req_ready), 64'h0);
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    chk("t1_alu_b", 64'(alu_b), 64'd3);
    chk("t1_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("t1_no_rsp_yet", 64'(rsp_valid), 64'd0);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(rsp_id), 64'd0);
    chk("t1_result", 64'(rsp_result), 64'd8);
    chk("t1_flags", 64'(rsp_flags), 64'h0);
    step();
    chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
    chk("t1_alu_a_held", 64'(alu_a), 64'd5);

    // SUB overflow from requester 2
    req_a[95:64] = 32'h8000_0000;
    req_b[95:64] = 32'd1;
    req_op[8:6]  = 3'b001;
    req_valid    = 4'b0100;
    #1;
    chk("t2_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0000;
    step();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_id", 64'(rsp_id), 64'd2);
    chk("t2_result", 64'(rsp_result), 64'h7FFF_FFFF);
    chk("t2_flags", 64'(rsp_flags), 64'b0011);
    step();

    // All four continuously valid after reset: order 0,1,2,3,0 at II=3
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'd10;
      req_op[3*i +: 3]  = 3'b000;
    end
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << (t % 4);
      #1;
      chk("rr_ready", 64'(req_ready), 64'(exp_oh));
      step();
      chk("rr_no_rsp", 64'(rsp_valid), 64'd0);
      step();
      chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rr_rsp_id", 64'(rsp_id), 64'(t % 4));
      chk("rr_result", 64'(rsp_result), 64'((t % 4) + 11));
      step();
    end

    // Backpressure: response from requester 0 held while requester 1 waits
    rsp_ready    = 1'b0;
    req_a[31:0]  = 32'd100;
    req_b[31:0]  = 32'd1;
    req_op[2:0]  = 3'b001;
    req_a[63:32] = 32'h10;
    req_b[63:32] = 32'h01;
    req_op[5:3]  = 3'b011;
    req_valid    = 4'b0001;
    #1;
    chk("bp_ready0", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0010;
    step();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_result", 64'(rsp_result), 64'd99);
    chk("bp_flags", 64'(rsp_flags), 64'b0001);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_result", 64'(rsp_result), 64'd99);
      chk("bp_hold_id", 64'(rsp_id), 64'd0);
      chk("bp_hold_ready", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_rsp_cleared", 64'(rsp_valid), 64'd0);
    chk("bp_ready1", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0000;
    chk("bp_alu_a1", 64'(alu_a), 64'h10);
    chk("bp_alu_ctrl1", 64'(alu_ctrl), 64'd3);
    step();
    chk("bp_rsp_id1", 64'(rsp_id), 64'd1);
    chk("bp_result1", 64'(rsp_result), 64'h11);
    chk("bp_flags1", 64'(rsp_flags), 64'h0);
    step();

    // Reset in EXEC drops the AND transaction
    req_a[95:64] = 32'hF0F0_F0F0;
    req_b[95:64] = 32'hFF00_FF00;
    req_op[8:6]  = 3'b010;
    req_valid    = 4'b0100;
    #1;
    chk("rx_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b1100;
    chk("rx_alu_a", 64'(alu_a), 64'hF0F0_F0F0);
    chk("rx_alu_ctrl", 64'(alu_ctrl), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rx_alu_a_clr", 64'(alu_a), 64'd0);
    chk("rx_alu_b_clr", 64'(alu_b), 64'd0);
    chk("rx_alu_ctrl_clr", 64'(alu_ctrl), 64'd0);
    chk("rx_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rx_ready_in_rst", 64'(req_ready), 64'h0);
    step();
    chk("rx_rsp_valid2", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rx_ready_lowest", 64'(req_ready), 64'h4);
    chk("rx_rsp_valid3", 64'(rsp_valid), 64'd0);
    step();
    req_valid = 4'b0000;
    chk("rx_alu_a2", 64'(alu_a), 64'hF0F0_F0F0);
    step();
    chk("rx_rsp_id", 64'(rsp_id), 64'd2);
    chk("rx_result", 64'(rsp_result), 64'hF000_F000);
    chk("rx_flags", 64'(rsp_flags), 64'b0100);
    step();

    // Unsupported op 111 from requester 3
    req_a[127:96] = 32'd7;
    req_b[127:96] = 32'd9;
    req_op[11:9]  = 3'b111;
    req_valid     = 4'b1000;
    #1;
    chk("u_ready", 64'(req_ready), 64'h8);
    step();
    req_valid = 4'b0000;
    chk("u_alu_ctrl", 64'(alu_ctrl), 64'd7);
    step();
    chk("u_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("u_rsp_id", 64'(rsp_id), 64'd3);
    chk("u_result", 64'(rsp_result), 64'd0);
    chk("u_flags", 64'(rsp_flags), 64'b1000);
    step();
    chk("u_done", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
